// File: rtl/riscv_pkg.sv
// Shared types for the pipeline memory arbiter: FSM states, owner encoding and data width.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_priority.sv
// Grant decision between fetch and data. Build with ARB_STARVE_GUARD_EN to let a waiting
// fetch win after STARVE_LIMIT consecutive data grants.
module arb_priority
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_fetch
);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved     = (starve_cnt == CW'(STARVE_LIMIT));
  assign grant_fetch = if_req & (~d_req | starved);

  // Only data grants that overtake a pending fetch count toward starvation.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (grant_fetch)
        starve_cnt <= '0;
      else if (if_req && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_prio;
  assign unused_prio = &{1'b0, clk_i, rstn_i, grant_en};
  assign grant_fetch = if_req & ~d_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and data stages: one outstanding access at a time.
// Optional fetch anti-starvation via ARB_STARVE_GUARD_EN (see arb_priority).
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  input  logic              if_kill_i,
  output logic              if_valid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [XLEN/8-1:0] d_be_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_valid_o,
  output logic [XLEN-1:0]   d_rdata_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q;
  logic       drop_q;
  logic       grant_en;
  logic       grant_fetch;
  logic       in_flight;
  logic       rsp_take;

  assign grant_en  = (state_q == IDLE) & (if_req_i | d_req_i);
  assign in_flight = (state_q == ISSUE) | (state_q == WAIT);
  assign rsp_take  = (state_q == WAIT) & mem_rvalid_i;

  arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .if_req      (if_req_i),
    .d_req       (d_req_i),
    .grant_en    (grant_en),
    .grant_fetch (grant_fetch)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_en) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = (state_q == ISSUE);
    if_valid_o = (state_q == RESP) & (owner_q == FETCH) & ~drop_q;
    d_valid_o  = (state_q == RESP) & (owner_q == DATA);
  end

  assign if_stall_o = if_req_i & ~if_valid_o;
  assign d_stall_o  = d_req_i & ~d_valid_o;

  // Request fields are captured at grant and held on the memory bus until the next grant.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q     <= FETCH;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (grant_en) begin
      if (grant_fetch) begin
        owner_q     <= FETCH;
        mem_we_o    <= 1'b0;
        mem_be_o    <= '1;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
      end else begin
        owner_q     <= DATA;
        mem_we_o    <= d_we_i;
        mem_be_o    <= d_be_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end
    end
  end

  // A killed fetch still completes on the memory side; only its response is swallowed.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      drop_q <= 1'b0;
    else if (state_q == IDLE)
      drop_q <= 1'b0;
    else if (in_flight && owner_q == FETCH && if_kill_i)
      drop_q <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else if (rsp_take) begin
      if (owner_q == FETCH && !drop_q && !if_kill_i)
        if_rdata_o <= mem_rdata_i;
      if (owner_q == DATA && !mem_we_o)
        d_rdata_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model with directed corners.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int SL = 2;
  localparam int BW = XLEN / 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            if_req_i, if_kill_i, if_valid_o, if_stall_o;
  logic [XLEN-1:0] if_addr_i, if_rdata_o;
  logic            d_req_i, d_we_i, d_valid_o, d_stall_o;
  logic [BW-1:0]   d_be_i, mem_be_o;
  logic [XLEN-1:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic            mem_req_o, mem_we_o, mem_rvalid_i;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state: one outstanding transaction plus a word memory.
  logic [31:0] ref_mem [logic [29:0]];
  bit          out_busy, out_fetch, out_drop, out_we;
  logic [31:0] out_addr, out_wdata, out_rdata;
  logic [3:0]  out_be;
  int          rv_cnt;
  bit          resp_due, cur_resp, just_issued, force_rv;
  logic [31:0] last_if, last_d;
  bit          d_known;
  int          starve;
  bit          rand_mode;
  int          lat_fix;
  bit          glog[$];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return {a[31:2], 2'b01} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rnd_faddr();
    return 32'h8000_0000 + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  task automatic clear_model();
    out_busy = 0; out_fetch = 0; out_drop = 0; out_we = 0;
    rv_cnt = 0; resp_due = 0; cur_resp = 0; just_issued = 0; force_rv = 0;
    last_if = '0; last_d = '0; d_known = 1; starve = 0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    if_req_i = 0; if_kill_i = 0; if_addr_i = '0;
    d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
    mem_rvalid_i = 0; mem_rdata_i = '0;
    clear_model();
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic drive_random();
    if_kill_i = 1'b0;
    if (if_req_i && $urandom_range(0, 15) == 0) begin
      if_kill_i = 1'b1;
      if_addr_i = rnd_faddr();
    end else if (if_valid_o || !if_req_i) begin
      if_req_i  = ($urandom_range(0, 9) < 7);
      if_addr_i = rnd_faddr();
    end
    if (d_valid_o || !d_req_i) begin
      d_req_i   = 1'($urandom_range(0, 1));
      d_we_i    = 1'($urandom_range(0, 1));
      d_be_i    = 4'($urandom_range(1, 15));
      d_addr_i  = 32'h0000_1000 + 32'($urandom_range(0, 63));
      d_wdata_i = $urandom;
    end
  endtask

  // One clock: account for the inputs now applied, drive the memory side, then check at negedge.
  task automatic step();
    bit          exp_issue, pick_fetch, exp_ifv, exp_dv;
    logic [31:0] w;
    if (if_kill_i && out_busy && out_fetch) out_drop = 1;
    exp_issue    = !out_busy && !cur_resp && (if_req_i || d_req_i);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (force_rv) begin
      mem_rvalid_i = 1'b1;
      force_rv     = 0;
    end else if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        if (!out_we) mem_rdata_i = out_rdata;
        resp_due = 1;
      end else if (rand_mode && just_issued && $urandom_range(0, 3) == 0) begin
        mem_rvalid_i = 1'b1;
      end
    end else if (rand_mode && !out_busy && $urandom_range(0, 3) == 0) begin
      mem_rvalid_i = 1'b1;
    end
    just_issued = 0;

    @(negedge clk_i);
    cur_resp = resp_due;
    resp_due = 0;
    exp_ifv  = cur_resp && out_fetch && !out_drop;
    exp_dv   = cur_resp && !out_fetch;
    chk("mem_req", mem_req_o, exp_issue);
    chk("if_valid", if_valid_o, exp_ifv);
    chk("d_valid", d_valid_o, exp_dv);
    chk("if_stall", if_stall_o, if_req_i && !exp_ifv);
    chk("d_stall", d_stall_o, d_req_i && !exp_dv);
    if (cur_resp) begin
      if (exp_ifv) last_if = out_rdata;
      if (exp_dv) begin
        if (!out_we) begin last_d = out_rdata; d_known = 1; end
        else d_known = 0;
      end
      out_busy = 0;
    end
    chk("if_rdata", if_rdata_o, last_if);
    if (d_known) chk("d_rdata", d_rdata_o, last_d);

    if (mem_req_o) begin
      if (if_req_i && d_req_i) pick_fetch = GUARD && (starve == SL);
      else                     pick_fetch = if_req_i;
      if (GUARD) begin
        if (pick_fetch)    starve = 0;
        else if (if_req_i) starve++;
      end
      if (pick_fetch) begin
        chk("iss_f_addr", mem_addr_o, if_addr_i);
        chk("iss_f_we", mem_we_o, 0);
        chk("iss_f_be", mem_be_o, 4'hF);
        out_we = 0; out_addr = if_addr_i; out_be = 4'hF; out_wdata = '0;
      end else begin
        chk("iss_d_addr", mem_addr_o, d_addr_i);
        chk("iss_d_we", mem_we_o, d_we_i);
        chk("iss_d_be", mem_be_o, d_be_i);
        if (d_we_i) chk("iss_d_wdata", mem_wdata_o, d_wdata_i);
        out_we = d_we_i; out_addr = d_addr_i; out_be = d_be_i; out_wdata = d_wdata_i;
      end
      out_rdata = rd_word(out_addr);
      if (out_we) begin
        w = out_rdata;
        for (int b = 0; b < 4; b++) if (out_be[b]) w[8*b +: 8] = out_wdata[8*b +: 8];
        ref_mem[out_addr[31:2]] = w;
      end
      out_busy    = 1;
      out_fetch   = pick_fetch;
      out_drop    = 0;
      rv_cnt      = (rand_mode ? $urandom_range(1, 4) : lat_fix) + 1;
      just_issued = 1;
      glog.push_back(pick_fetch);
    end
    if (rand_mode) drive_random();
  endtask

  task automatic run_until(input int sel, input int bound);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      step();
      hit = (sel == 0) ? mem_req_o : (sel == 1) ? if_valid_o : d_valid_o;
    end
    chk("wait_event", hit, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_mode = 0;
    lat_fix   = 1;

    // Fetch-only latency: mem_req at cycle 1, valid at cycle 3.
    do_reset();
    ref_mem[30'h2000_0000] = 32'h0000_0013;
    if_addr_i = 32'h8000_0000;
    if_req_i  = 1;
    #1 chk("t1_stall_c0", if_stall_o, 1);
    step(); chk("t1_req_c1", mem_req_o, 1); chk("t1_addr", mem_addr_o, 32'h8000_0000);
    step(); chk("t1_req_c2", mem_req_o, 0); chk("t1_stall_c2", if_stall_o, 1);
    step(); chk("t1_valid_c3", if_valid_o, 1); chk("t1_rdata", if_rdata_o, 32'h0000_0013);
    if_req_i = 0;
    step();

    // Simultaneous fetch and store: store first, fetch on the second mem_req.
    if_req_i = 1; if_addr_i = 32'h8000_0004;
    d_req_i = 1; d_we_i = 1; d_be_i = 4'hF; d_addr_i = 32'h0000_1000; d_wdata_i = 32'hDEAD_BEEF;
    run_until(0, 4);
    chk("t2_first_we", mem_we_o, 1); chk("t2_first_addr", mem_addr_o, 32'h0000_1000);
    run_until(2, 8);
    d_req_i = 0;
    run_until(0, 4);
    chk("t2_second_addr", mem_addr_o, 32'h8000_0004); chk("t2_second_we", mem_we_o, 0);
    run_until(1, 8);
    if_req_i = 0;
    step();

    // Kill during WAIT, then a redirected fetch with its own data.
    lat_fix = 4;
    ref_mem[30'h2000_0004] = 32'hCAFE_0010;
    if_req_i = 1; if_addr_i = 32'h8000_0008;
    step(); step();
    if_kill_i = 1;
    step();
    if_kill_i = 0; if_addr_i = 32'h8000_0010;
    run_until(0, 12);
    chk("t3_redirect_addr", mem_addr_o, 32'h8000_0010);
    run_until(1, 12);
    chk("t3_rdata", if_rdata_o, 32'hCAFE_0010);
    if_req_i = 0;
    step();

    // Reset while waiting; late rvalid must be ignored.
    lat_fix = 5;
    if_req_i = 1; if_addr_i = 32'h8000_0020;
    step(); step();
    rstn_i = 0; if_req_i = 0;
    clear_model();
    #1;
    chk("t4_rst_req", mem_req_o, 0); chk("t4_rst_we", mem_we_o, 0);
    chk("t4_rst_be", mem_be_o, 0); chk("t4_rst_addr", mem_addr_o, 0);
    chk("t4_rst_wdata", mem_wdata_o, 0); chk("t4_rst_ifv", if_valid_o, 0);
    chk("t4_rst_dv", d_valid_o, 0); chk("t4_rst_ifrd", if_rdata_o, 0);
    @(negedge clk_i);
    rstn_i = 1;
    force_rv = 1;
    step(); step(); step();
    lat_fix = 1;
    ref_mem[30'h2000_0009] = 32'h1234_5678;
    if_req_i = 1; if_addr_i = 32'h8000_0024;
    run_until(1, 8);
    chk("t4_after_rdata", if_rdata_o, 32'h1234_5678);
    if_req_i = 0;
    step();

    // Byte store.
    lat_fix = 2;
    d_req_i = 1; d_we_i = 1; d_be_i = 4'h2; d_addr_i = 32'h0000_1001; d_wdata_i = 32'h0000_AB00;
    run_until(0, 4);
    chk("t5_be", mem_be_o, 4'h2); chk("t5_addr", mem_addr_o, 32'h0000_1001);
    chk("t5_wdata", mem_wdata_o, 32'h0000_AB00);
    run_until(2, 8);
    chk("t5_no_fetch", if_valid_o, 0);
    d_req_i = 0;
    step();

    // Both requests held: grant order follows priority (and starve guard when built).
    do_reset();
    lat_fix = 1;
    glog.delete();
    if_req_i = 1; if_addr_i = 32'h8000_0040;
    d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h0000_1100;
    for (int i = 0; i < 80 && glog.size() < 6; i++) begin
      step();
      if (if_valid_o) if_addr_i = if_addr_i + 32'd4;
      if (d_valid_o)  d_addr_i  = d_addr_i + 32'd4;
    end
    chk("t6_grant_cnt", glog.size(), 6);
    for (int i = 0; i < glog.size() && i < 6; i++)
      chk($sformatf("t6_grant%0d", i), glog[i], GUARD && (i % 3 == 2));

    // Randomized traffic against the model.
    do_reset();
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    if_req_i = 0; d_req_i = 0; if_kill_i = 0;
    for (int i = 0; i < 20 && (out_busy || cur_resp); i++) step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage RV32I pipeline.
- Arbitrates between the two, sequences one outstanding memory transaction at a time, and routes the response back to the owner.
- Produces the per-requester stall signals that feed the pipeline stall/flush logic.
- Supports discarding an in-flight fetch that a branch flush has killed.

Parameters:
- XLEN, riscv_pkg::XLEN, address/data width.
- STARVE_LIMIT, 4, consecutive data wins allowed while a fetch waits (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request, held until if_valid_o.
- if_addr_i  in  XLEN  fetch address.
- if_kill_i  in  1  discard the current fetch (flush).
- if_valid_o  out  1  fetch response pulse.
- if_rdata_o  out  XLEN  fetched instruction.
- if_stall_o  out  1  if_req_i & ~if_valid_o.
- d_req_i  in  1  data request, held until d_valid_o.
- d_we_i  in  1  1 = store.
- d_be_i  in  XLEN/8  byte enables.
- d_addr_i  in  XLEN  data address.
- d_wdata_i  in  XLEN  store data.
- d_valid_o  out  1  data response pulse (loads and stores).
- d_rdata_o  out  XLEN  load data.
- d_stall_o  out  1  d_req_i & ~d_valid_o.
- mem_req_o  out  1  one-cycle request pulse to memory.
- mem_we_o  out  1  write enable.
- mem_be_o  out  XLEN/8  byte enables.
- mem_addr_o  out  XLEN  memory address.
- mem_wdata_o  out  XLEN  write data.
- mem_rvalid_i  in  1  memory completion; acks writes as well as reads.
- mem_rdata_i  in  XLEN  memory read data.

Behaviour:
- Reset: clock is clk_i; reset is asynchronous, active-low on rstn_i. All registered outputs go to 0, state = IDLE, owner = FETCH, drop flag = 0, starve count = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is pending, latch owner and request fields, go to ISSUE.
  - Priority: data over fetch, because the data access belongs to the older instruction.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle): mem_req_o = 1 with latched we/be/addr/wdata. A fetch always drives we = 0 and be = all-ones. Go to WAIT.
- WAIT: hold the latched fields and keep mem_req_o = 0. When mem_rvalid_i = 1, capture mem_rdata_i and go to RESP.
- RESP (1 cycle): pulse the owner's valid with the captured data, then go to IDLE.
  - The requester drops or changes its request by the end of its valid cycle.
  - RESP never issues, so no double issue is possible.
- Latency: request seen in IDLE at cycle 0 → mem_req_o at cycle 1 → rvalid at cycle ≥2 → valid_o one cycle after rvalid. Minimum is 3 cycles to valid; peak throughput is 1 access per 4 cycles.
- rdata outputs hold their last value when valid_o = 0.
- if_kill_i:
  - While the owner is FETCH in ISSUE or WAIT: set the drop flag. The transaction still completes on the memory side, RESP suppresses if_valid_o, and the flag clears in IDLE.
  - In IDLE: no effect.
  - In RESP: if_valid_o still pulses; the fetch stage discards it.
- Data accesses are never killed.
- mem_rvalid_i outside WAIT is ignored.
- Reset during ISSUE/WAIT: return to IDLE. A late rvalid arriving after reset is ignored.
- Simultaneous if_req_i and d_req_i in IDLE: data wins, fetch stays stalled.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - Starve counter counts data grants issued while if_req_i is pending, and resets on any fetch grant.
  - When the count equals STARVE_LIMIT and both requests are pending, fetch wins.
- Undefined: strict data priority, and no counter logic.

Decomposition:
- riscv_pkg holds:
  - arb_state_t (IDLE, ISSUE, WAIT, RESP).
  - arb_owner_t (FETCH, DATA).
  - XLEN.
- Sub-module arb_priority: the combinational grant decision plus the starve counter. The counter is absent when the macro is off.

Test Plan:
- Fetch only, addr 0x80000000, memory returns 0x00000013 one cycle after mem_req_o → mem_req_o at cycle 1; if_valid_o = 1 with 0x00000013 at cycle 3; if_stall_o high in cycles 0–2.
- Simultaneous fetch 0x80000004 and store 0x00001000 data 0xDEADBEEF be 0xF → store issues first with mem_we_o = 1. The fetch issues only after d_valid_o, on the second mem_req_o.
- Kill while fetch in WAIT (memory latency 4) → no if_valid_o. The next fetch to 0x80000010 is served normally with its own data.
- Reset asserted in WAIT, then rvalid arrives after release → all outputs 0, no valid pulse, state IDLE. A new fetch completes normally.
- Byte store be 0x2 to 0x00001001, data 0x0000AB00 → mem_be_o = 0x2, mem_addr_o = 0x00001001; d_valid_o on completion with no fetch interference.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT = 2, data and fetch requests held continuously → grant sequence D, D, F, D, D, F.
